// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state, control bundle and control presets for pipe_hazard_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
        logic mem_err;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_DEFAULT = '{
        pc_en: 1'b1, pc_sel: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
        mem_wb_flush: 1'b0, mem_err: 1'b0
    };

    // Whole pipe frozen, bubble pushed into WB while data memory is busy.
    localparam pipe_ctrl_t PIPE_CTRL_HOLD = '{
        pc_en: 1'b0, pc_sel: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
        mem_wb_flush: 1'b1, mem_err: 1'b0
    };

    localparam pipe_ctrl_t PIPE_CTRL_ERR = '{
        pc_en: 1'b0, pc_sel: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
        mem_wb_flush: 1'b1, mem_err: 1'b1
    };

    // Normal-flow controls once no memory stall applies; branch beats load-use.
    function automatic pipe_ctrl_t run_ctrl(input logic br_taken, input logic lu);
        pipe_ctrl_t c;
        c = PIPE_CTRL_DEFAULT;
        if (br_taken) begin
            c.pc_sel      = 1'b1;
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (lu) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// rtl/hazard_lu_detect.sv - combinational load-use comparator between EX load and ID sources
module hazard_lu_detect (
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    input  logic       is_load,
    output logic       lu
);

    // x0 is never a real dependency.
    assign lu = is_load && (rd_addr != 5'd0) &&
                ((rd_addr == rs1_addr) || (rd_addr == rs2_addr));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [4:0]  ID_i_rs1_addr,
    input  logic [4:0]  ID_i_rs2_addr,
    input  logic [4:0]  EX_i_rd_addr,
    input  logic        EX_i_is_load,
    input  logic        EX_i_br_taken,
    input  logic        MEM_i_req,
    input  logic        MEM_i_ack,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic        o_if_id_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_en,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_flush,
    output logic        o_mem_err,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    hz_state_e   state;
    logic [WAIT_W-1:0] wait_cnt;
    logic        lu;
    logic        ms;
    pipe_ctrl_t  ctrl;

    hazard_lu_detect u_lu (
        .rs1_addr (ID_i_rs1_addr),
        .rs2_addr (ID_i_rs2_addr),
        .rd_addr  (EX_i_rd_addr),
        .is_load  (EX_i_is_load),
        .lu       (lu)
    );

    assign ms = MEM_i_req && !MEM_i_ack;

    always_comb begin
        ctrl = PIPE_CTRL_DEFAULT;
        if (i_reset_n) begin
            case (state)
                RUN:      ctrl = ms ? PIPE_CTRL_HOLD : run_ctrl(EX_i_br_taken, lu);
                MEM_WAIT: ctrl = MEM_i_ack ? run_ctrl(EX_i_br_taken, lu) : PIPE_CTRL_HOLD;
                ERR:      ctrl = PIPE_CTRL_ERR;
                default:  ctrl = PIPE_CTRL_DEFAULT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ms) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MEM_i_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state    <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    assign o_pc_en        = ctrl.pc_en;
    assign o_pc_sel       = ctrl.pc_sel;
    assign o_if_id_en     = ctrl.if_id_en;
    assign o_if_id_flush  = ctrl.if_id_flush;
    assign o_id_ex_en     = ctrl.id_ex_en;
    assign o_id_ex_flush  = ctrl.id_ex_flush;
    assign o_ex_mem_en    = ctrl.ex_mem_en;
    assign o_mem_wb_flush = ctrl.mem_wb_flush;
    assign o_mem_err      = ctrl.mem_err;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_en)
                stall_cnt <= stall_cnt + 32'd1;
            if (ctrl.if_id_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a cycle-count reference model
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    // Bit order: pc_en pc_sel if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en mem_wb_flush mem_err
    localparam logic [8:0] E_DEF  = 9'b1_0_1_0_1_0_1_0_0;
    localparam logic [8:0] E_HOLD = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_ERR  = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] E_BR   = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] E_LU   = 9'b0_0_0_0_1_1_1_0_0;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
        bit          chk_cnt;
        int          seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        ld, br, req, ack;
    logic        pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_flush, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: cycles spent waiting on memory (0 = not waiting), error latch, event tallies.
    int   m_wait = 0;
    bit   m_err  = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   m_cnt_known = 0;
    int   m_seq = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .WAIT_W(8)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .ID_i_rs1_addr  (rs1),
        .ID_i_rs2_addr  (rs2),
        .EX_i_rd_addr   (rd),
        .EX_i_is_load   (ld),
        .EX_i_br_taken  (br),
        .MEM_i_req      (req),
        .MEM_i_ack      (ack),
        .o_pc_en        (pc_en),
        .o_pc_sel       (pc_sel),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_flush (mem_wb_flush),
        .o_mem_err      (mem_err),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] flow(input bit b, input bit l);
        if (b) return E_BR;
        if (l) return E_LU;
        return E_DEF;
    endfunction

    task automatic cyc(input bit r, input bit l_ld, input bit b, input bit rq, input bit ak,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        exp_t e;
        bit   use_dep;
        @(posedge clk);
        #1;
        rst_n = r; ld = l_ld; br = b; req = rq; ack = ak; rs1 = a1; rs2 = a2; rd = d;
        use_dep = l_ld && (d != 0) && (d == a1 || d == a2);
        if (!r)             e.ctrl = E_DEF;
        else if (m_err)     e.ctrl = E_ERR;
        else if (m_wait > 0) e.ctrl = ak ? flow(b, use_dep) : E_HOLD;
        else                e.ctrl = (rq && !ak) ? E_HOLD : flow(b, use_dep);
`ifdef PIPE_HAZARD_PERF_EN
        e.sc = 32'(m_stall);
        e.fc = 32'(m_flush);
`else
        e.sc = 32'd0;
        e.fc = 32'd0;
`endif
        e.chk_cnt = m_cnt_known;
        e.seq = m_seq;
        m_seq++;
        q.push_back(e);
        if (!r) begin
            m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0; m_cnt_known = 1;
        end else begin
            m_stall += (e.ctrl[8] == 1'b0) ? 1 : 0;
            m_flush += e.ctrl[5] ? 1 : 0;
            if (!m_err) begin
                if (m_wait > 0) begin
                    if (ak)                m_wait = 0;
                    else if (m_wait == TMO) m_err = 1;
                    else                   m_wait++;
                end else if (rq && !ak) begin
                    m_wait = 1;
                end
            end
        end
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    endtask

    // Monitor: every sampled cycle consumes one expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e = q.pop_front();
            got = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, mem_wb_flush, mem_err};
            n_assert++;
            if (got !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl seq=%0d got=%b exp=%b", e.seq, got, e.ctrl);
            end
            if (e.chk_cnt) begin
                n_assert++;
                if (stall_cnt !== e.sc) begin
                    n_fail++;
                    $display("FAIL stall_cnt seq=%0d got=%0d exp=%0d", e.seq, stall_cnt, e.sc);
                end
                n_assert++;
                if (flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL flush_cnt seq=%0d got=%0d exp=%0d", e.seq, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        rst_n = 0; ld = 0; br = 0; req = 0; ack = 0; rs1 = 0; rs2 = 0; rd = 0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 5'd5, 5'd5, 5'd5);
        idle();
        // Load-use on rs2, then release
        cyc(1, 1, 0, 0, 0, 5'd1, 5'd5, 5'd5);
        idle();
        // Load to x0 never stalls
        cyc(1, 1, 0, 0, 0, 5'd0, 5'd7, 5'd0);
        // Branch overrides load-use
        cyc(1, 1, 1, 0, 0, 5'd5, 5'd2, 5'd5);
        idle();
        // Same-cycle ack: no stall
        cyc(1, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
        // Ack three cycles after req
        cyc(1, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        cyc(1, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        cyc(1, 1, 0, 1, 0, 5'd1, 5'd2, 5'd1);
        cyc(1, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
        idle();
        // Timeout to ERR, linger, then one reset edge
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        cyc(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        idle();
        // Reset while branch taken
        cyc(0, 1, 1, 0, 0, 5'd4, 5'd4, 5'd4);
        cyc(0, 0, 1, 1, 0, 5'd4, 5'd4, 5'd4);
        idle();
        // Timeout boundary: ack on the last legal wait cycle avoids ERR
        cyc(1, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < TMO - 1; i++) cyc(1, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        cyc(1, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
        idle();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) > 3,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) < 3,
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
        end
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
